// File: rtl/pulse_link_pkg.sv
// Shared definitions for the on-off-keyed wake-up link.
// The transmitter and the receiver both import these timing defaults so they agree on slot timing.
package pulse_link_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      GUARD = 2'd3
   } state_t;

   localparam int DEF_WIDTH        = 8;
   localparam int DEF_SLOT_CYCLES  = 10000;
   localparam int DEF_PULSE_CYCLES = 1;
   localparam int DEF_MID_CYCLE    = 5000;

endpackage

// File: rtl/slot_timer.sv
// Wrapping bit-slot counter for pulse_tx. It runs while a frame is active and
// rests at zero otherwise.
module slot_timer #(
   parameter int SLOT_CYCLES  = 10000,
   parameter int PULSE_CYCLES = 1,
   parameter int MID_CYCLE    = 5000,
   localparam int CW          = $clog2(SLOT_CYCLES)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic run_i,
   output logic slot_end_o,
   output logic pulse_win_o,
   output logic mid_o
);

   localparam logic [CW-1:0] LAST_CNT  = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] PULSE_CNT = CW'(PULSE_CYCLES);
   localparam logic [CW-1:0] MID_CNT   = CW'(MID_CYCLE);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      if (!run_i || cnt_q == LAST_CNT) cnt_d = '0;
      else                             cnt_d = cnt_q + CW'(1);
   end

   assign slot_end_o  = run_i && (cnt_q == LAST_CNT);
   // These two flags describe the count held in the next cycle, so the
   // pulse_tx output registers line up with the slot they belong to.
   assign pulse_win_o = (cnt_d < PULSE_CNT);
   assign mid_o       = (cnt_d == MID_CNT);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pulse_tx.sv
// Frames a parallel word as start slot, WIDTH data slots (MSB first) and a guard slot.
// It emits an rfout pulse at the head of every 1-slot and an sh_en strobe mid-way through each data slot.
module pulse_tx
   import pulse_link_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
   parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
   parameter int MID_CYCLE    = DEF_MID_CYCLE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data,
   output logic             busy,
   output logic             done,
   output logic             rfout,
   output logic             sh_en
);

   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   if (WIDTH < 1 || PULSE_CYCLES < 1 || PULSE_CYCLES > MID_CYCLE ||
       MID_CYCLE >= SLOT_CYCLES) begin : g_bad_params
      $error("pulse_tx: illegal WIDTH/PULSE_CYCLES/MID_CYCLE/SLOT_CYCLES combination");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;
   logic             busy_q, done_q, rfout_q, sh_en_q;
   logic             busy_d, done_d, rfout_d, sh_en_d;
   logic             slot_bit_d;
   logic             slot_end, pulse_win_nxt, mid_nxt;

   slot_timer #(
      .SLOT_CYCLES (SLOT_CYCLES),
      .PULSE_CYCLES(PULSE_CYCLES),
      .MID_CYCLE   (MID_CYCLE)
   ) u_slot_timer (
      .clk_i      (clk),
      .rst_ni     (rst),
      .run_i      (state_q != IDLE),
      .slot_end_o (slot_end),
      .pulse_win_o(pulse_win_nxt),
      .mid_o      (mid_nxt)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: if (start) begin
            state_d  = START;
            shreg_d  = data;
            bitcnt_d = '0;
         end
         START: if (slot_end) state_d = DATA;
         DATA: if (slot_end) begin
            shreg_d = shreg_q << 1;
            if (bitcnt_q == LAST_BIT) begin
               state_d  = GUARD;
               bitcnt_d = '0;
            end else begin
               bitcnt_d = bitcnt_q + BW'(1);
            end
         end
         GUARD: if (slot_end) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are derived from the next state so they can be registered without a cycle of lag.
      unique case (state_d)
         START:   slot_bit_d = 1'b1;
         DATA:    slot_bit_d = shreg_d[WIDTH-1];
         default: slot_bit_d = 1'b0;
      endcase
      rfout_d = pulse_win_nxt && slot_bit_d;
      sh_en_d = (state_d == DATA) && mid_nxt;
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rfout_q  <= 1'b0;
         sh_en_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rfout_q  <= rfout_d;
         sh_en_q  <= sh_en_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign rfout = rfout_q;
   assign sh_en = sh_en_q;

endmodule

// File: tb/tb_pulse_tx.sv
// Scoreboard bench for pulse_tx with small timing parameters.
// The driver predicts each accepted frame's events, and the monitor matches them against the DUT outputs.
module tb_pulse_tx;

   localparam int W = 3;
   localparam int S = 20;
   localparam int P = 1;
   localparam int M = 10;
   localparam int FRAME = (W + 2) * S;

   typedef enum int {EV_RF, EV_SH, EV_DONE} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      longint   cyc;
   } ev_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] data = '0;
   logic         busy, done, rfout, sh_en;

   longint cyc = 0;
   longint frame_first = 0;
   longint frame_done = 0;
   ev_t    exp_q[$];
   int     n_checks = 0;
   int     n_errors = 0;

   pulse_tx #(
      .WIDTH       (W),
      .SLOT_CYCLES (S),
      .PULSE_CYCLES(P),
      .MID_CYCLE   (M)
   ) dut (
      .clk  (clk),
      .rst  (rst_n),
      .start(start),
      .data (data),
      .busy (busy),
      .done (done),
      .rfout(rfout),
      .sh_en(sh_en)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference model: a frame's events follow directly from the slot arithmetic.
   task automatic accept(input logic [W-1:0] d, input longint first);
      int slot, pos;
      bit b;
      frame_first = first;
      frame_done  = first + FRAME;
      for (int t = 0; t < FRAME; t++) begin
         slot = t / S;
         pos  = t % S;
         if (slot == 0)      b = 1'b1;
         else if (slot <= W) b = d[W - slot];
         else                b = 1'b0;
         if (b && pos < P) exp_q.push_back('{EV_RF, first + t});
         if (slot >= 1 && slot <= W && pos == M) exp_q.push_back('{EV_SH, first + t});
      end
      exp_q.push_back('{EV_DONE, first + FRAME});
   endtask

   function automatic bit model_busy(input longint c);
      return (c >= frame_first) && (c < frame_done);
   endfunction

   // Called at a falling edge; the inputs are sampled at the next rising edge.
   task automatic step(input bit s, input logic [W-1:0] d);
      start = s;
      data  = d;
      if (s && rst_n && !model_busy(cyc)) accept(d, cyc + 1);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, W'($urandom));
   endtask

   task automatic expect_event(input ev_kind_e k);
      ev_t ev;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL spurious_%s: cycle %0d output high, none expected", k.name(), cyc);
      end else begin
         ev = exp_q.pop_front();
         check({"event_kind_", k.name()}, longint'(k), longint'(ev.kind));
         check({"event_cycle_", k.name()}, cyc, ev.cyc);
      end
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         n_checks++;
         n_errors++;
         $display("FAIL missed_%s: event due at cycle %0d not seen by cycle %0d",
                  exp_q[0].kind.name(), exp_q[0].cyc, cyc);
         void'(exp_q.pop_front());
      end
      check("busy", busy, model_busy(cyc));
      if (rfout === 1'b1) expect_event(EV_RF);
      if (sh_en === 1'b1) expect_event(EV_SH);
      if (done === 1'b1)  expect_event(EV_DONE);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_rfout", rfout, 0);
      check("reset_sh_en", sh_en, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      rst_n = 1'b1;
      repeat (50) step(1'b0, '0);

      // Frame 110 with ignored starts at frame cycles 15 and 60, then a restart in the done cycle.
      step(1'b1, 3'b110);
      for (int t = 0; t <= FRAME; t++) begin
         if (t == 15)         step(1'b1, 3'b001);
         else if (t == 60)    step(1'b1, 3'b011);
         else if (t == FRAME) step(1'b1, 3'b000);
         else                 step(1'b0, W'($urandom));
      end
      idle(FRAME + 5);

      // Frame 110 interrupted by reset while rfout is high in the second data slot.
      step(1'b1, 3'b110);
      idle(40);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      frame_first = 0;
      frame_done  = 0;
      #1;
      check("async_rst_rfout", rfout, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_sh_en", sh_en, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(60);

      // Random requests, many of which land while a frame is in progress.
      repeat (3000) step($urandom_range(0, 7) == 0, W'($urandom));
      start = 1'b0;
      while (cyc <= frame_done + 2) step(1'b0, W'($urandom));

      check("final_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pulse_tx.md
# pulse_tx

Serializing on-off-keyed pulse transmitter that generates the `rfin`-style stream consumed by `fsm_sync`. A parallel word is framed as one start slot, WIDTH data slots (MSB first) and one guard slot; each slot begins with a short `rfout` pulse when its bit is 1. A one-cycle mid-slot `sh_en` strobe is emitted for every data slot, giving loopback benches and the receiver-side shift logic a reference sampling point. Sits at the TX end of the wake-up link, driven by the digital controller at 10 MHz.

## Interface
- WIDTH, 8: data bits per frame.
- SLOT_CYCLES, 10000: clock cycles per bit slot (1 ms at 10 MHz).
- PULSE_CYCLES, 1: width of an `rfout` pulse in cycles.
- MID_CYCLE, 5000: slot-relative cycle index at which `sh_en` fires.
- clk  in  1  system clock; one clock domain only.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- start  in  1  request to send; accepted only when `busy`=0.
- data  in  WIDTH  frame payload; sampled on the accept edge only.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the guard slot ends.
- rfout  out  1  pulse stream to the RF front end.
- sh_en  out  1  one-cycle mid-slot strobe, data slots only.

## Operation
- States: IDLE, START, DATA, GUARD.
- IDLE: all outputs 0 except `done`. `start`=1 sampled → latch `data` into shift register, clear slot counter, go START.
- START: one slot, pulse always sent (bit = 1), `sh_en` never fires → DATA.
- DATA: WIDTH slots; slot bit = shift register MSB; shift left at slot end; bit counter counts 0..WIDTH-1 → GUARD after last slot.
- GUARD: one slot, no pulse, no `sh_en` → IDLE, `done`=1 for that first IDLE cycle.
- Slot counter runs 0..SLOT_CYCLES-1 and wraps; slot-end = counter at SLOT_CYCLES-1.
- `rfout` = 1 while slot counter < PULSE_CYCLES and slot bit = 1.
- `sh_en` = 1 while in DATA and slot counter == MID_CYCLE.
- `start` while `busy`=1: ignored, not queued. `data` changes during a frame have no effect.
- `start` in the `done` cycle (busy=0): accepted; the new frame begins immediately.
- Legal parameters: 1 ≤ PULSE_CYCLES ≤ MID_CYCLE < SLOT_CYCLES, WIDTH ≥ 1; violations are caught by an elaboration-time check.
- Counter widths: $clog2(SLOT_CYCLES) for the slot counter, $clog2(WIDTH+1) for the bit counter; no overflow is possible within legal parameters.

## Timing
- All outputs are registered and glitch-free.
- Reset value: state IDLE, counters 0, shift register 0, busy=0, done=0, rfout=0, sh_en=0. Assertion mid-frame forces all outputs to 0 asynchronously and drops the frame; after deassertion the block sits in IDLE.
- Cycle 0 = first cycle after the accept edge. Slot s spans cycles s·SLOT_CYCLES … (s+1)·SLOT_CYCLES−1; s=0 is the start slot, s=1..WIDTH are data, s=WIDTH+1 is the guard slot.
- busy=1 for cycles 0 … (WIDTH+2)·SLOT_CYCLES−1; at cycle (WIDTH+2)·SLOT_CYCLES busy=0 and done=1.
- Latency from `start` to the first `rfout` pulse: 1 edge (rfout=1 in cycle 0).

## Structure
- Shared package `pulse_link_pkg`: state enum (IDLE/START/DATA/GUARD) and default timing constants (SLOT_CYCLES=10000, PULSE_CYCLES=1, MID_CYCLE=5000). `fsm_sync` imports the same constants so TX and RX agree on timing.
- One sub-module: `slot_timer` (wrapping slot counter with slot_end, pulse_win and mid outputs); the FSM, shift register and bit counter live in `pulse_tx`.

## Test plan
Small parameters throughout: WIDTH=3, SLOT_CYCLES=20, PULSE_CYCLES=1, MID_CYCLE=10.
- Reset (rst=0), then release, `start` held 0 → all outputs 0 indefinitely.
- data=3'b110, one-cycle `start` → rfout=1 at cycles 0, 20, 40, 0 at cycle 60 and 80; sh_en at 30, 50, 70; busy for cycles 0–99; done=1 and busy=0 at cycle 100.
- data=3'b000 → only the start pulse at cycle 0; sh_en still fires at 30, 50, 70; done at 100.
- `start` pulsed at cycles 15 and 60 with different data → ignored, and the waveform is identical to the first frame; `start` in the done cycle (100) → new frame with rfout=1 at cycle 101.
- rst=0 at cycle 45 (mid data slot) → rfout, sh_en and busy drop to 0 without waiting for a clock edge; after release, no output until the next `start`.
- Loopback: `pulse_tx` drives `fsm_sync.rfin`, `sh_en` feeds `fsm_sync.sh_en`; data 3'b101 with default timing → receiver state samples 1, 0, 1.
